// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: one requester's request/grant/read-return bundle.
// The requester drives through the master modport; the arbiter uses slave.
interface ram_port_arbiter_if #(
    parameter int MEM_WIDTH = 16,
    parameter int ADDR_SIZE = 10
);
    logic                 req;
    logic                 we;
    logic [ADDR_SIZE-1:0] addr;
    logic [MEM_WIDTH-1:0] wdata;
    logic                 gnt;
    logic                 rvalid;
    logic [MEM_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one single-port RAM between two
// requesters. RAM command pins come straight from registers, and a tag
// pipeline remembers which requester issued each read so its data can be
// handed back after the RAM's fixed read latency.
module ram_port_arbiter #(
    parameter int MEM_WIDTH  = 16,
    parameter int ADDR_SIZE  = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ram_port_arbiter_if.slave    a_port,
    ram_port_arbiter_if.slave    b_port,
    output logic                 ram_blk_select,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [MEM_WIDTH-1:0] ram_din,
    output logic                 ram_addr_en,
    output logic                 ram_dout_en,
    output logic                 ram_rst,
    input  logic [MEM_WIDTH-1:0] ram_dout,
    output logic                 busy
);
    // One stage per cycle between accept and valid ram_dout, plus the
    // command-register cycle.
    localparam int TAG_DEPTH = RD_LATENCY + 1;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    req_id_e              last_gnt_q, last_gnt_d;
    logic                 blk_select_q, blk_select_d;
    logic                 wr_en_q, wr_en_d;
    logic                 rd_en_q, rd_en_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [MEM_WIDTH-1:0] din_q, din_d;
    logic [TAG_DEPTH-1:0] tag_valid_q, tag_valid_d;
    logic [TAG_DEPTH-1:0] tag_id_q, tag_id_d;
    logic [1:0]           rst_sync_q, rst_sync_d;
    logic                 en_q, en_d;

    logic                 a_gnt;
    logic                 b_gnt;
    logic                 accept;
    logic                 sel_we;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [MEM_WIDTH-1:0] sel_wdata;

    // Grant: a lone requester wins; on a tie the side not served last wins.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst_n) begin
            if (a_port.req && b_port.req) begin
                a_gnt = (last_gnt_q == REQ_B);
                b_gnt = (last_gnt_q == REQ_A);
            end else begin
                a_gnt = a_port.req;
                b_gnt = b_port.req;
            end
        end
    end

    // Mux the accepted requester's command fields.
    always_comb begin
        accept    = a_gnt || b_gnt;
        sel_we    = a_port.we;
        sel_addr  = a_port.addr;
        sel_wdata = a_port.wdata;
        if (b_gnt) begin
            sel_we    = b_port.we;
            sel_addr  = b_port.addr;
            sel_wdata = b_port.wdata;
        end
    end

    // Next state: command register, tag shift, round-robin pointer, reset sync.
    always_comb begin
        last_gnt_d   = last_gnt_q;
        blk_select_d = accept;
        wr_en_d      = accept && sel_we;
        rd_en_d      = accept && !sel_we;
        addr_d       = addr_q;
        din_d        = din_q;
        tag_valid_d  = {tag_valid_q[TAG_DEPTH-2:0], (accept && !sel_we)};
        tag_id_d     = {tag_id_q[TAG_DEPTH-2:0], b_gnt};
        rst_sync_d   = {rst_sync_q[0], 1'b0};
        en_d         = 1'b1;
        if (accept) begin
            addr_d = sel_addr;
            din_d  = sel_wdata;
        end
        if (a_gnt) begin
            last_gnt_d = REQ_A;
        end else if (b_gnt) begin
            last_gnt_d = REQ_B;
        end
    end

    // State registers; reset drops every in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q   <= REQ_B;
            blk_select_q <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            tag_valid_q  <= '0;
            tag_id_q     <= '0;
            rst_sync_q   <= 2'b11;
            en_q         <= 1'b0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            blk_select_q <= blk_select_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            tag_valid_q  <= tag_valid_d;
            tag_id_q     <= tag_id_d;
            rst_sync_q   <= rst_sync_d;
            en_q         <= en_d;
        end
    end

    assign a_port.gnt    = a_gnt;
    assign b_port.gnt    = b_gnt;
    assign a_port.rvalid = tag_valid_q[TAG_DEPTH-1] && (tag_id_q[TAG_DEPTH-1] == 1'b0);
    assign b_port.rvalid = tag_valid_q[TAG_DEPTH-1] && (tag_id_q[TAG_DEPTH-1] == 1'b1);
    assign a_port.rdata  = ram_dout;
    assign b_port.rdata  = ram_dout;

    assign ram_blk_select = blk_select_q;
    assign ram_wr_en      = wr_en_q;
    assign ram_rd_en      = rd_en_q;
    assign ram_addr       = addr_q;
    assign ram_din        = din_q;
    assign ram_addr_en    = en_q;
    assign ram_dout_en    = en_q;
    assign ram_rst        = rst_sync_q[1];
    assign busy           = (|tag_valid_q) || blk_select_q;
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester round-robin arbiter that shares one single-port RAM (`ram`, MEM_WIDTH x MEM_DEPTH) between requester A and requester B. It accepts at most one read or write per cycle, drives the RAM command pins from registers, and tracks in-flight reads in a tag pipeline. Each read's data is returned to the requester that issued it, with fixed latency. It sits between two client engines and the RAM instance.

## Interface
- `MEM_WIDTH`, 16, data width; must match the RAM.
- `ADDR_SIZE`, 10, address width; must match the RAM.
- `RD_LATENCY`, 2, RAM read latency in cycles from the command edge to valid `ram_dout`. Legal values are 1..4. It is 1 for RAM DOUT_PIPELINE="FALSE" and 2 for "TRUE".
- `clk  in  1`  single clock, rising edge.
- `rst_n  in  1`  asynchronous, active-low reset.
- `a_req, b_req  in  1`  request valid.
- `a_we, b_we  in  1`  1 = write, 0 = read.
- `a_addr, b_addr  in  ADDR_SIZE`  request address.
- `a_wdata, b_wdata  in  MEM_WIDTH`  write data.
- `a_gnt, b_gnt  out  1`  combinational accept. A transfer occurs on `x_req && x_gnt`.
- `a_rvalid, b_rvalid  out  1`  read data valid, one cycle per accepted read.
- `a_rdata, b_rdata  out  MEM_WIDTH`  read data. Both carry `ram_dout`.
- `ram_blk_select, ram_wr_en, ram_rd_en  out  1`  RAM command, registered.
- `ram_addr  out  ADDR_SIZE`, `ram_din  out  MEM_WIDTH`  RAM address and data, registered.
- `ram_addr_en, ram_dout_en  out  1`  constant 1 after reset, 0 during reset.
- `ram_rst  out  1`  active-high RAM reset = `~rst_n`, registered through 2 flops. Asserts asynchronously and deasserts synchronously.
- `ram_dout  in  MEM_WIDTH`  RAM read data.
- `busy  out  1`  1 while any read is in flight or a command register is loaded.

## Operation
- **Grant logic:**
  - Only one requester asserted: it is granted.
  - Both asserted: the one not favoured by `last_gnt` is granted.
  - `last_gnt` resets to B, so A wins the first tie.
  - `last_gnt` updates only on an accepted transfer.
  - At most one of `a_gnt`/`b_gnt` is high per cycle. `gnt` never asserts without the matching `req`.
- **Requester stability:** a requester holds `req`, `we`, `addr` and `wdata` stable until granted. The arbiter does not latch unaccepted requests.
- **Command register:** on accept, the next edge loads `ram_addr`, `ram_din` and `ram_wr_en = we`, `ram_rd_en = ~we`, with `ram_blk_select = 1`. With no accept, `blk_select`, `wr_en` and `rd_en` load 0; `ram_addr`/`ram_din` hold.
- **Tag pipeline:** depth RD_LATENCY+1, each stage holding {valid, id}. A stage enters only for accepted reads; writes inject nothing. `x_rvalid` = last-stage valid && id==x.
- **Ordering:** commands reach the RAM in accept order. A read accepted the cycle after a write to the same address returns the new data.
- **Parity:** the RAM's parity output is not consumed.
- **Reset (rst_n low, any time):**
  - Tag pipe cleared, all `gnt`/`rvalid`/`ram_*` enables 0, `ram_addr`/`ram_din` 0, `last_gnt` = B, `busy` 0.
  - In-flight reads are dropped and produce no `rvalid` after reset.

## Timing
- Accept in cycle N → RAM command visible in cycle N+1 → `x_rvalid` high in cycle N+1+RD_LATENCY, for exactly 1 cycle.
- Back-to-back accepts every cycle are supported. Throughput is 1 transfer/cycle in aggregate.
- Under continuous contention the grants alternate A, B, A, B. Each requester waits at most 1 cycle.
- Writes have no response. Completion is implied at the N+1 edge.
- `busy` falls in the cycle after the last tag leaves the pipeline, with no command loaded.
- `gnt` depends only on `req` and `last_gnt`. There is no combinational path from `ram_dout`.

## Test plan
- **Reset values:** hold `rst_n`=0 with random inputs → all outputs 0 and `ram_rst`=1. Release → `ram_rst` falls 2 edges later; `ram_addr_en`/`ram_dout_en` = 1.
- **Single requester write/read:** A writes 0x1234 @0x005, then reads @0x005 in the next cycle with RD_LATENCY=2. Required: `ram_wr_en` pulses at N+1 and `a_rvalid` at N+4 (N = write-accept cycle; read accepted at N+1) with `a_rdata`=0x1234. `b_rvalid` never asserts.
- **Tie:** A and B both request reads continuously for 6 cycles, A @0x010 and B @0x020, RAM preloaded with 0xAAAA @0x010 and 0xBBBB @0x020. Required: grants alternate A,B,A,B,A,B; `a_rvalid`/`b_rvalid` alternate with 0xAAAA/0xBBBB at accept+3.
- **Mixed traffic:** A writes 0x00FF @0x3FF while B reads @0x3FF in the next cycle. Required: B reads 0x00FF, which checks the top-address boundary and ordering.
- **Reset mid-operation:** 3 reads in flight, pull `rst_n` low for 1 cycle. Required: no `rvalid` afterwards, `busy`=0, and the first tie after reset goes to A.
- **Latency sweep:** repeat the single-requester write/read with RD_LATENCY=1 and RD_LATENCY=4. Required: `rvalid` at accept+2 and accept+5 respectively.
